// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: input/collision side and score/fuel side signals of the game sequencer.
// The slave modport is the sequencer's view; the master modport drives its inputs.
interface game_flow_ctrl_if;
  logic       startOfFrame;
  logic       onesec;
  logic       startKey;
  logic       collision_in;
  logic       fueltank_in;
  logic [3:0] playerSpeedReq;
  logic       fuel_zero;
  logic       win;
  logic       statsResetN;
  logic       onesec_g;
  logic       collision_g;
  logic       fueltank_g;
  logic [3:0] playerSpeed_g;
  logic [2:0] phase;
  logic [3:0] countdownDigit;
  modport slave (
    input  startOfFrame, onesec, startKey, collision_in, fueltank_in, playerSpeedReq, fuel_zero, win,
    output statsResetN, onesec_g, collision_g, fueltank_g, playerSpeed_g, phase, countdownDigit
  );
  modport master (
    output startOfFrame, onesec, startKey, collision_in, fueltank_in, playerSpeedReq, fuel_zero, win,
    input  statsResetN, onesec_g, collision_g, fueltank_g, playerSpeed_g, phase, countdownDigit
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: Road Fighter game phase sequencer gating the score/fuel/speed datapath inputs.
// Phases and counters are registered; the gates are combinational on the registered phase.
module game_flow_ctrl #(
  parameter int COUNTDOWN_SEC = 3,
  parameter int CRASH_FRAMES  = 60,
  parameter int END_HOLD_SEC  = 5
) (
  input logic clk,
  input logic resetN,
  game_flow_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, COUNTDOWN = 3'd1, RUN = 3'd2, CRASH = 3'd3, OVER = 3'd4, WON = 3'd5} phase_t;
  localparam logic [3:0] CD = 4'(COUNTDOWN_SEC);
  localparam logic [7:0] CF = 8'(CRASH_FRAMES);
  localparam logic [3:0] EH = 4'(END_HOLD_SEC);
  phase_t     r_state, w_state;
  logic [3:0] r_digit, w_digit;
  logic [7:0] r_crash, w_crash;
  logic [3:0] r_hold, w_hold;
  logic       r_key, r_stats;
  logic       w_start, w_run, w_live;
  assign w_start = bus.startKey & ~r_key;
  assign w_run   = r_state == RUN;
  assign w_live  = w_run | (r_state == CRASH);
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_state <= IDLE;
      r_digit <= '0;
      r_crash <= '0;
      r_hold  <= '0;
      r_key   <= 1'b0;
      r_stats <= 1'b0;
    end else begin
      r_state <= w_state;
      r_digit <= w_digit;
      r_crash <= w_crash;
      r_hold  <= w_hold;
      r_key   <= bus.startKey;
      r_stats <= r_state != IDLE;
    end
  always_comb begin
    w_state = r_state;
    w_digit = r_digit;
    w_crash = r_crash;
    w_hold  = r_hold;
    case (r_state)
      IDLE: if (w_start) begin
        w_state = COUNTDOWN;
        w_digit = CD;
      end
      COUNTDOWN: if (bus.onesec) begin
        w_digit = r_digit - 4'd1;
        w_state = r_digit == 4'd1 ? RUN : COUNTDOWN;
      end
      RUN, CRASH:
        if (bus.win) begin
          w_state = WON;
          w_hold  = EH;
        end else if (bus.fuel_zero) begin
          w_state = OVER;
          w_hold  = EH;
        end else if (w_run && bus.collision_in) begin
          w_state = CRASH;
          w_crash = CF;
        end else if (!w_run && bus.startOfFrame) begin
          w_crash = r_crash - 8'd1;
          w_state = r_crash == 8'd1 ? RUN : CRASH;
        end
      OVER, WON: if (bus.onesec) begin
        w_hold  = r_hold - 4'd1;
        w_state = r_hold == 4'd1 ? IDLE : r_state;
      end
      default: w_state = IDLE;
    endcase
  end
  // Collisions and seconds keep flowing during CRASH; fuel and speed do not.
  assign bus.onesec_g       = w_live & bus.onesec;
  assign bus.collision_g    = w_live & bus.collision_in;
  assign bus.fueltank_g     = w_run & bus.fueltank_in;
  assign bus.playerSpeed_g  = w_run ? bus.playerSpeedReq : 4'd0;
  assign bus.phase          = r_state;
  assign bus.countdownDigit = r_digit;
  assign bus.statsResetN    = r_stats;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed scenarios plus a randomized run of game_flow_ctrl
// against a phase-level behavioural model of the game rules.
module tb_game_flow_ctrl;
  localparam int CD = 3, CF = 60, EH = 5;
  logic clk = 1'b0, resetN = 1'b0;
  int checks = 0, errors = 0;
  int m_phase, m_digit, m_crash, m_hold;
  bit m_key, m_stats;
  bit g_os, g_col, g_ft, e_os, e_col, e_ft;
  logic [3:0] g_spd;
  int e_spd;
  game_flow_ctrl_if bus();
  game_flow_ctrl #(.COUNTDOWN_SEC(CD), .CRASH_FRAMES(CF), .END_HOLD_SEC(EH)) dut (.clk(clk), .resetN(resetN), .bus(bus));
  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_digit = 0; m_crash = 0; m_hold = 0; m_key = 0; m_stats = 0;
  endtask

  // Drive one clk worth of inputs, record gated outputs before the edge, advance the model.
  task automatic step(input bit sof, os, key, col, ft, input int spd, input bit fz, w);
    bus.startOfFrame = sof; bus.onesec = os; bus.startKey = key; bus.collision_in = col;
    bus.fueltank_in = ft; bus.playerSpeedReq = 4'(spd); bus.fuel_zero = fz; bus.win = w;
    #1;
    g_os = bus.onesec_g; g_col = bus.collision_g; g_ft = bus.fueltank_g; g_spd = bus.playerSpeed_g;
    e_os  = (m_phase == 2 || m_phase == 3) && os;
    e_col = (m_phase == 2 || m_phase == 3) && col;
    e_ft  = m_phase == 2 && ft;
    e_spd = m_phase == 2 ? spd : 0;
    m_stats = m_phase != 0;
    case (m_phase)
      0: if (key && !m_key) begin m_phase = 1; m_digit = CD; end
      1: if (os) begin m_digit--; if (m_digit == 0) m_phase = 2; end
      2, 3: begin
        if (w) begin m_phase = 5; m_hold = EH; end
        else if (fz) begin m_phase = 4; m_hold = EH; end
        else if (m_phase == 2 && col) begin m_phase = 3; m_crash = CF; end
        else if (m_phase == 3 && sof) begin m_crash--; if (m_crash == 0) m_phase = 2; end
      end
      default: if (os) begin m_hold--; if (m_hold == 0) m_phase = 0; end
    endcase
    m_key = key;
    @(posedge clk); #1;
  endtask

  task automatic start_game();
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < CD; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    bus.startOfFrame = 1; bus.onesec = 1; bus.startKey = 0; bus.collision_in = 1;
    bus.fueltank_in = 1; bus.playerSpeedReq = 4'd15; bus.fuel_zero = 0; bus.win = 0;
    #2;
    checks += 4;
    if (bus.phase !== 3'd0) begin errors++; $display("FAIL rst_phase: got %0d expected 0", bus.phase); end
    if (bus.countdownDigit !== 4'd0) begin errors++; $display("FAIL rst_digit: got %0d expected 0", bus.countdownDigit); end
    if (bus.statsResetN !== 1'b0) begin errors++; $display("FAIL rst_stats: got %b expected 0", bus.statsResetN); end
    if ({bus.onesec_g, bus.collision_g, bus.fueltank_g, bus.playerSpeed_g} !== 7'd0) begin
      errors++; $display("FAIL rst_gates: got %b %b %b %0d expected all 0", bus.onesec_g, bus.collision_g, bus.fueltank_g, bus.playerSpeed_g);
    end
    @(posedge clk); #1;
    resetN = 1'b1;
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    checks += 2;
    if (bus.phase !== 3'd0) begin errors++; $display("FAIL rst_idle_phase: got %0d expected 0", bus.phase); end
    if (bus.statsResetN !== 1'b0) begin errors++; $display("FAIL rst_idle_stats: got %b expected 0", bus.statsResetN); end
  endtask

  task automatic test_countdown();
    step(0, 0, 1, 0, 0, 0, 0, 0);
    checks += 3;
    if (bus.phase !== 3'd1) begin errors++; $display("FAIL cd_enter_phase: got %0d expected 1", bus.phase); end
    if (bus.countdownDigit !== 4'(CD)) begin errors++; $display("FAIL cd_enter_digit: got %0d expected %0d", bus.countdownDigit, CD); end
    if (bus.statsResetN !== 1'b0) begin errors++; $display("FAIL cd_stats_lag: got %b expected 0", bus.statsResetN); end
    step(0, 0, 0, 1, 0, 0, 1, 1);
    checks += 2;
    if (bus.statsResetN !== 1'b1) begin errors++; $display("FAIL cd_stats: got %b expected 1", bus.statsResetN); end
    if (bus.phase !== 3'd1) begin errors++; $display("FAIL cd_ignore_exits: got %0d expected 1", bus.phase); end
    for (int i = 1; i <= CD; i++) begin
      step(1, 1, 0, 0, 1, 5, 0, 0);
      checks += 3;
      if (bus.countdownDigit !== 4'(CD - i)) begin errors++; $display("FAIL cd_digit%0d: got %0d expected %0d", i, bus.countdownDigit, CD - i); end
      if (bus.phase !== 3'(i == CD ? 2 : 1)) begin errors++; $display("FAIL cd_phase%0d: got %0d expected %0d", i, bus.phase, i == CD ? 2 : 1); end
      if ({g_os, g_ft, g_spd} !== 6'd0) begin errors++; $display("FAIL cd_gates%0d: got %b %b %0d expected 0", i, g_os, g_ft, g_spd); end
    end
  endtask

  task automatic test_crash();
    int zero_frames = 0, leaks = 0;
    step(0, 1, 0, 0, 1, 7, 0, 0);
    checks += 3;
    if (g_spd !== 4'd7) begin errors++; $display("FAIL run_speed: got %0d expected 7", g_spd); end
    if (g_os !== 1'b1) begin errors++; $display("FAIL run_onesec: got %b expected 1", g_os); end
    if (g_ft !== 1'b1) begin errors++; $display("FAIL run_fuel: got %b expected 1", g_ft); end
    step(0, 0, 0, 1, 0, 7, 0, 0);
    checks += 3;
    if (g_col !== 1'b1) begin errors++; $display("FAIL crash_col_g: got %b expected 1", g_col); end
    if (g_spd !== 4'd7) begin errors++; $display("FAIL crash_entry_speed: got %0d expected 7", g_spd); end
    if (bus.phase !== 3'd3) begin errors++; $display("FAIL crash_phase: got %0d expected 3", bus.phase); end
    for (int f = 0; f < CF + 5 && bus.phase == 3'd3; f++) begin
      step(1, 0, 0, 0, 0, 7, 0, 0);
      zero_frames++;
      if (g_spd !== 4'd0) leaks++;
      if (bus.phase == 3'd3) begin
        step(0, 0, 0, 0, 1, 7, 0, 0);
        if (g_spd !== 4'd0 || g_ft !== 1'b0) leaks++;
      end
    end
    step(0, 0, 0, 0, 0, 7, 0, 0);
    checks += 4;
    if (zero_frames != CF) begin errors++; $display("FAIL crash_frames: got %0d expected %0d", zero_frames, CF); end
    if (leaks != 0) begin errors++; $display("FAIL crash_leak: got %0d nonzero cycles expected 0", leaks); end
    if (bus.phase !== 3'd2) begin errors++; $display("FAIL crash_return: got %0d expected 2", bus.phase); end
    if (g_spd !== 4'd7) begin errors++; $display("FAIL crash_speed_back: got %0d expected 7", g_spd); end
  endtask

  task automatic test_win_fuel();
    step(0, 0, 0, 1, 0, 3, 1, 1);
    checks += 2;
    if (bus.phase !== 3'd5) begin errors++; $display("FAIL win_prio: got %0d expected 5", bus.phase); end
    if (bus.statsResetN !== 1'b1) begin errors++; $display("FAIL win_stats: got %b expected 1", bus.statsResetN); end
    for (int s = 1; s <= EH; s++) begin
      step(0, 0, s == 2, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1, 9, 0, 0);
      checks += 2;
      if (bus.phase !== 3'(s == EH ? 0 : 5)) begin errors++; $display("FAIL hold_phase%0d: got %0d expected %0d", s, bus.phase, s == EH ? 0 : 5); end
      if ({g_os, g_ft, g_spd} !== 6'd0) begin errors++; $display("FAIL hold_gates%0d: got %b %b %0d expected 0", s, g_os, g_ft, g_spd); end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.statsResetN !== 1'b0) begin errors++; $display("FAIL win_idle_stats: got %b expected 0", bus.statsResetN); end
  endtask

  task automatic test_crash_fuel();
    start_game();
    step(0, 0, 0, 1, 0, 4, 0, 0);
    step(0, 1, 0, 1, 1, 7, 0, 0);
    checks += 3;
    if (bus.phase !== 3'd3) begin errors++; $display("FAIL cf_crash: got %0d expected 3", bus.phase); end
    if ({g_os, g_col} !== 2'b11) begin errors++; $display("FAIL cf_pass: got %b%b expected 11", g_os, g_col); end
    if ({g_ft, g_spd} !== 5'd0) begin errors++; $display("FAIL cf_block: got %b %0d expected 0", g_ft, g_spd); end
    for (int f = 1; f <= 10; f++) step(1, 0, 0, 0, 0, 7, f == 10, 0);
    step(0, 1, 0, 1, 1, 7, 0, 0);
    checks += 2;
    if (bus.phase !== 3'd4) begin errors++; $display("FAIL cf_over: got %0d expected 4", bus.phase); end
    if ({g_os, g_col, g_ft, g_spd} !== 7'd0) begin errors++; $display("FAIL cf_over_gates: got %b %b %b %0d expected 0", g_os, g_col, g_ft, g_spd); end
    for (int s = 0; s < 20 && bus.phase != 3'd0; s++) step(0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.phase !== 3'd0) begin errors++; $display("FAIL cf_idle: got %0d expected 0", bus.phase); end
  endtask

  task automatic test_start_held();
    int entries = 0;
    logic [2:0] pp;
    for (int s = 1; s <= 12; s++)
      for (int j = 0; j < 4; j++) begin
        pp = bus.phase;
        step(0, j == 3, 1, 0, 0, 0, 0, s == 4 && j == 0);
        if (pp != 3'd1 && bus.phase == 3'd1) entries++;
      end
    checks += 2;
    if (entries != 1) begin errors++; $display("FAIL held_entries: got %0d expected 1", entries); end
    if (bus.phase !== 3'd0) begin errors++; $display("FAIL held_idle: got %0d expected 0", bus.phase); end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.phase !== 3'd1) begin errors++; $display("FAIL held_repress: got %0d expected 1", bus.phase); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < CD; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    bus.onesec = 1; bus.fueltank_in = 1; bus.collision_in = 0; bus.playerSpeedReq = 4'd9;
    #1;
    checks++;
    if (bus.playerSpeed_g !== 4'd9) begin errors++; $display("FAIL mid_run_speed: got %0d expected 9", bus.playerSpeed_g); end
    resetN = 1'b0;
    #1;
    checks += 3;
    if (bus.phase !== 3'd0) begin errors++; $display("FAIL mid_phase: got %0d expected 0", bus.phase); end
    if (bus.countdownDigit !== 4'd0) begin errors++; $display("FAIL mid_digit: got %0d expected 0", bus.countdownDigit); end
    if ({bus.onesec_g, bus.fueltank_g, bus.playerSpeed_g} !== 6'd0) begin
      errors++; $display("FAIL mid_gates: got %b %b %0d expected 0", bus.onesec_g, bus.fueltank_g, bus.playerSpeed_g);
    end
    #1;
    resetN = 1'b1;
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0);
    checks += 2;
    if (bus.statsResetN !== 1'b0) begin errors++; $display("FAIL mid_stats: got %b expected 0", bus.statsResetN); end
    if (bus.phase !== 3'd0) begin errors++; $display("FAIL mid_idle: got %0d expected 0", bus.phase); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 4000; n++) begin
      step($urandom % 4 == 0, $urandom % 16 == 0, $urandom % 24 == 0, $urandom % 12 == 0,
           $urandom % 2 == 1, int'($urandom % 16), $urandom % 300 == 0, $urandom % 300 == 0);
      checks++;
      if (bus.phase !== 3'(m_phase) || bus.countdownDigit !== 4'(m_digit) || bus.statsResetN !== m_stats ||
          g_os !== e_os || g_col !== e_col || g_ft !== e_ft || g_spd !== 4'(e_spd)) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand@%0d: got ph=%0d dg=%0d st=%b g=%b%b%b/%0d expected ph=%0d dg=%0d st=%b g=%b%b%b/%0d", n,
                   bus.phase, bus.countdownDigit, bus.statsResetN, g_os, g_col, g_ft, g_spd,
                   m_phase, m_digit, m_stats, e_os, e_col, e_ft, e_spd);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_countdown();
    test_crash();
    test_win_fuel();
    test_crash_fuel();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
